fetch_sequencer: RTL and testbench



---
 rtl/fetch_pkg.sv | 23 ++
 rtl/branch_target_calc.sv | 64 ++++++
 rtl/fetch_sequencer.sv | 143 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
//   state_t       : sequencer state (FETCH issues a request, HOLD presents to decode)
//   *_DEFAULT     : default PC width, instruction width and PC stride
//   align_mask()  : mask that clears the low address bits below the PC stride
package fetch_pkg;

    localparam int PC_W_DEFAULT    = 16;
    localparam int INSTR_W_DEFAULT = 16;
    localparam int PC_INC_DEFAULT  = 4;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Alignment mask for a power-of-two stride: ~(inc - 1). Callers cast to their width.
    function automatic logic [31:0] align_mask(input int unsigned inc);
        logic [31:0] inc_v;
        inc_v = 32'(inc);
        return ~(inc_v - 32'd1);
    endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Combinational redirect-address calculator for the instruction accepted by decode.
// Ports:
//   instr_pc      in  : address of the accepted instruction
//   br_offset     in  : signed branch offset in instructions (words)
//   jmp_valid     in  : absolute jump requested
//   jmp_target    in  : jump address (low bits are forced to stride alignment)
//   br_taken      in  : relative branch requested
//   redirect_addr out : address to fetch next when redirect is set
//   redirect      out : a jump or taken branch overrides sequential flow
// Jump wins over branch. All arithmetic wraps modulo 2^PC_W.
module branch_target_calc
    import fetch_pkg::*;
#(
    parameter int PC_W   = PC_W_DEFAULT,
    parameter int PC_INC = PC_INC_DEFAULT
) (
    input  logic [PC_W-1:0] instr_pc,
    input  logic [15:0]     br_offset,
    input  logic            jmp_valid,
    input  logic [PC_W-1:0] jmp_target,
    input  logic            br_taken,
    output logic [PC_W-1:0] redirect_addr,
    output logic            redirect
);

    // Stride is a power of two, so scaling the word offset is a left shift.
    localparam int              SHIFT = $clog2(PC_INC);
    localparam logic [PC_W-1:0] INC   = PC_W'(PC_INC);

    logic [PC_W-1:0] mask_s;
    logic [PC_W-1:0] off_ext_s;
    logic [PC_W-1:0] br_target_s;

    assign mask_s = PC_W'(align_mask(PC_INC));

    // Sign-extend (or truncate) the 16-bit offset to the address width.
    generate
        if (PC_W > 16) begin : g_sext
            assign off_ext_s = {{(PC_W - 16){br_offset[15]}}, br_offset};
        end else begin : g_trunc
            assign off_ext_s = br_offset[PC_W-1:0];
        end
    endgenerate

    // Branches are relative to the instruction after the branch.
    assign br_target_s = instr_pc + INC + (off_ext_s << SHIFT);

    // Redirect selection: jump, then branch, otherwise no redirect.
    always_comb begin
        redirect      = 1'b0;
        redirect_addr = {PC_W{1'b0}};
        if (jmp_valid) begin
            redirect      = 1'b1;
            redirect_addr = jmp_target & mask_s;
        end else if (br_taken) begin
            redirect      = 1'b1;
            redirect_addr = br_target_s;
        end else begin
            redirect      = 1'b0;
            redirect_addr = {PC_W{1'b0}};
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Next-PC and instruction-fetch sequencer.
// Fetches the instruction at the external PC register value, holds it for decode
// with a valid/ready handshake, and computes the value the PC register loads on
// every edge (hold, increment, branch or jump).
// Ports:
//   clock, reset           : rising-edge clock, synchronous active-high reset
//   pc                     : current PC register value
//   nextPC                 : value loaded into the PC register each edge
//   imem_req/imem_addr     : instruction-memory request and address
//   imem_ready/imem_rdata  : memory data strobe and instruction
//   instr/instr_pc         : held instruction and its address
//   instr_valid/instr_ready: decode handshake
//   br_taken/br_offset     : taken branch and word offset of the accepted instruction
//   jmp_valid/jmp_target   : jump and absolute target of the accepted instruction
// The block keeps no PC copy; it relies on the PC register loading nextPC every edge.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int PC_W    = PC_W_DEFAULT,
    parameter int INSTR_W = INSTR_W_DEFAULT,
    parameter int PC_INC  = PC_INC_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    nextPC,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               br_taken,
    input  logic [15:0]        br_offset,
    input  logic               jmp_valid,
    input  logic [PC_W-1:0]    jmp_target
);

    localparam logic [PC_W-1:0] INC = PC_W'(PC_INC);

    state_t             state_r;
    state_t             next_state_s;
    logic [INSTR_W-1:0] instr_r;
    logic [PC_W-1:0]    instr_pc_r;
    logic               instr_valid_r;
    logic               capture_s;
    logic               accept_s;
    logic               redirect_s;
    logic [PC_W-1:0]    redirect_addr_s;
    logic [PC_W-1:0]    next_pc_s;
    logic               imem_req_s;
    logic [PC_W-1:0]    imem_addr_s;

    branch_target_calc #(
        .PC_W   (PC_W),
        .PC_INC (PC_INC)
    ) u_btc (
        .instr_pc      (instr_pc_r),
        .br_offset     (br_offset),
        .jmp_valid     (jmp_valid),
        .jmp_target    (jmp_target),
        .br_taken      (br_taken),
        .redirect_addr (redirect_addr_s),
        .redirect      (redirect_s)
    );

    // Next state, nextPC mux and memory request; reset forces a quiet, zeroed interface.
    always_comb begin
        next_state_s = state_r;
        next_pc_s    = pc;
        imem_req_s   = 1'b0;
        imem_addr_s  = {PC_W{1'b0}};
        capture_s    = 1'b0;
        accept_s     = 1'b0;
        if (reset) begin
            next_state_s = FETCH;
            next_pc_s    = {PC_W{1'b0}};
        end else begin
            case (state_r)
                FETCH: begin
                    imem_req_s  = 1'b1;
                    imem_addr_s = pc;
                    if (imem_ready) begin
                        capture_s    = 1'b1;
                        next_pc_s    = pc + INC;
                        next_state_s = HOLD;
                    end else begin
                        next_pc_s = pc;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        accept_s     = 1'b1;
                        next_state_s = FETCH;
                        // Without a redirect, pc already equals instr_pc + stride.
                        if (redirect_s) begin
                            next_pc_s = redirect_addr_s;
                        end else begin
                            next_pc_s = pc;
                        end
                    end else begin
                        next_pc_s = pc;
                    end
                end
                default: begin
                    next_state_s = FETCH;
                    next_pc_s    = pc;
                end
            endcase
        end
    end

    // State register plus the held instruction, its address and the valid flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= FETCH;
            instr_r       <= {INSTR_W{1'b0}};
            instr_pc_r    <= {PC_W{1'b0}};
            instr_valid_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (capture_s) begin
                instr_r       <= imem_rdata;
                instr_pc_r    <= pc;
                instr_valid_r <= 1'b1;
            end else if (accept_s) begin
                instr_valid_r <= 1'b0;
            end else begin
                instr_valid_r <= instr_valid_r;
            end
        end
    end

    assign nextPC      = next_pc_s;
    assign imem_req    = imem_req_s;
    assign imem_addr   = imem_addr_s;
    assign instr       = instr_r;
    assign instr_pc    = instr_pc_r;
    assign instr_valid = instr_valid_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a randomized run
// checked against a transaction-level reference model of the fetch/decode handshake.
module tb_fetch_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] pc;
    logic [15:0] nextPC;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        br_taken;
    logic [15:0] br_offset;
    logic        jmp_valid;
    logic [15:0] jmp_target;

    int total = 0;
    int bad   = 0;

    // Reference model: is an instruction held for decode, and which one.
    bit          m_hold  = 1'b0;
    logic [15:0] m_instr = 16'h0000;
    logic [15:0] m_ipc   = 16'h0000;

    fetch_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .pc          (pc),
        .nextPC      (nextPC),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .br_taken    (br_taken),
        .br_offset   (br_offset),
        .jmp_valid   (jmp_valid),
        .jmp_target  (jmp_target)
    );

    always #5 clock = ~clock;

    // Expected PC-register load value from the current inputs and model state.
    function automatic logic [15:0] model_next();
        int t;
        if (reset) return 16'h0000;
        if (!m_hold) return imem_ready ? 16'(pc + 16'd4) : pc;
        if (!instr_ready) return pc;
        if (jmp_valid) return jmp_target & 16'hFFFC;
        if (br_taken) begin
            t = int'(m_ipc) + 4 + 4 * int'($signed(br_offset));
            return 16'(t);
        end
        return pc;
    endfunction

    // Advance one clock: update the model, act as the PC register and the memory.
    task automatic tick();
        logic [15:0] nx;
        nx = model_next();
        @(posedge clock);
        if (reset) begin
            m_hold = 1'b0; m_instr = 16'h0000; m_ipc = 16'h0000;
        end else if (!m_hold) begin
            if (imem_ready) begin
                m_hold = 1'b1; m_instr = imem_rdata; m_ipc = pc;
            end
        end else if (instr_ready) begin
            m_hold = 1'b0;
        end
        @(negedge clock);
        pc = nx;
        imem_rdata = 16'hA000 + pc;
    endtask

    task automatic clear_redirect();
        br_taken = 1'b0; br_offset = 16'h0000; jmp_valid = 1'b0; jmp_target = 16'h0000;
    endtask

    task automatic go_hold();
        instr_ready = 1'b0; imem_ready = 1'b1;
        if (!m_hold) tick();
    endtask

    task automatic go_fetch();
        clear_redirect(); instr_ready = 1'b1;
        if (m_hold) tick();
        instr_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; imem_ready = 1'b1; instr_ready = 1'b1; clear_redirect();
        for (int i = 0; i < 2; i++) begin
            pc = 16'h1234; imem_rdata = 16'h5555; #1;
            total++; if (nextPC !== 16'h0000) begin bad++; $display("FAIL reset_nextpc: got %h want 0000", nextPC); end
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
            total++; if (imem_addr !== 16'h0000) begin bad++; $display("FAIL reset_addr: got %h want 0000", imem_addr); end
            tick();
        end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        total++; if (instr_pc !== 16'h0000) begin bad++; $display("FAIL reset_instr_pc: got %h want 0000", instr_pc); end
        reset = 1'b0; pc = 16'h0000; imem_rdata = 16'hA000; #1;
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL release_req: got %b want 1", imem_req); end
        total++; if (imem_addr !== 16'h0000) begin bad++; $display("FAIL release_addr: got %h want 0000", imem_addr); end
    endtask

    task automatic test_sequential();
        imem_ready = 1'b1; instr_ready = 1'b1; clear_redirect();
        for (int i = 0; i < 6; i++) begin
            #1;
            total++; if (instr_valid !== ((i % 2) == 1)) begin bad++; $display("FAIL seq_valid[%0d]: got %b", i, instr_valid); end
            if ((i % 2) == 1) begin
                total++; if (instr_pc !== 16'(4 * (i / 2))) begin bad++; $display("FAIL seq_instr_pc[%0d]: got %h want %h", i, instr_pc, 16'(4 * (i / 2))); end
                total++; if (instr !== 16'(16'hA000 + 4 * (i / 2))) begin bad++; $display("FAIL seq_instr[%0d]: got %h want %h", i, instr, 16'(16'hA000 + 4 * (i / 2))); end
            end
            total++; if (nextPC !== model_next()) begin bad++; $display("FAIL seq_nextpc[%0d]: got %h want %h", i, nextPC, model_next()); end
            tick();
        end
    endtask

    task automatic test_mem_wait();
        logic [15:0] p0;
        go_fetch();
        p0 = pc; imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (imem_addr !== p0) begin bad++; $display("FAIL wait_addr[%0d]: got %h want %h", i, imem_addr, p0); end
            total++; if (nextPC !== p0) begin bad++; $display("FAIL wait_nextpc[%0d]: got %h want %h", i, nextPC, p0); end
            tick();
        end
        imem_ready = 1'b1; #1;
        total++; if (nextPC !== 16'(p0 + 16'd4)) begin bad++; $display("FAIL wait_done_nextpc: got %h want %h", nextPC, 16'(p0 + 16'd4)); end
        tick();
        total++; if (instr_pc !== p0 || instr !== 16'(16'hA000 + p0)) begin bad++; $display("FAIL wait_capture: got %h/%h want %h/%h", instr_pc, instr, p0, 16'(16'hA000 + p0)); end
    endtask

    task automatic test_backpressure();
        logic [15:0] e_pc, e_in;
        go_hold();
        e_pc = m_ipc; e_in = m_instr; instr_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            br_taken = 1'b1; jmp_valid = 1'b1; jmp_target = 16'($urandom); br_offset = 16'($urandom); #1;
            total++; if (instr !== e_in || instr_pc !== e_pc || instr_valid !== 1'b1) begin bad++; $display("FAIL bp_hold[%0d]: got %h/%h/%b want %h/%h/1", i, instr, instr_pc, instr_valid, e_in, e_pc); end
            total++; if (nextPC !== pc) begin bad++; $display("FAIL bp_nextpc[%0d]: got %h want %h", i, nextPC, pc); end
            tick();
        end
        clear_redirect(); instr_ready = 1'b1; #1;
        total++; if (nextPC !== 16'(e_pc + 16'd4)) begin bad++; $display("FAIL bp_accept: got %h want %h", nextPC, 16'(e_pc + 16'd4)); end
        tick(); instr_ready = 1'b0; #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 16'(e_pc + 16'd4)) begin bad++; $display("FAIL bp_refetch: got %b/%h want 1/%h", imem_req, imem_addr, 16'(e_pc + 16'd4)); end
    endtask

    task automatic test_redirect();
        go_hold();
        instr_ready = 1'b1; jmp_valid = 1'b1; jmp_target = 16'h0012; #1;
        total++; if (nextPC !== 16'h0010) begin bad++; $display("FAIL jump_align: got %h want 0010", nextPC); end
        tick(); clear_redirect();
        go_hold(); #1;
        total++; if (instr_pc !== 16'h0010) begin bad++; $display("FAIL redir_instr_pc: got %h want 0010", instr_pc); end
        instr_ready = 1'b1; br_taken = 1'b1; br_offset = 16'hFFFE; #1;
        total++; if (nextPC !== 16'h000C) begin bad++; $display("FAIL branch_back: got %h want 000C", nextPC); end
        jmp_valid = 1'b1; jmp_target = 16'h0043; #1;
        total++; if (nextPC !== 16'h0040) begin bad++; $display("FAIL jump_wins: got %h want 0040", nextPC); end
        tick(); clear_redirect(); instr_ready = 1'b0; #1;
        total++; if (imem_addr !== 16'h0040) begin bad++; $display("FAIL redir_fetch: got %h want 0040", imem_addr); end
        imem_ready = 1'b0; br_taken = 1'b1; br_offset = 16'h0100; jmp_valid = 1'b1; jmp_target = 16'h8000; instr_ready = 1'b1; #1;
        total++; if (nextPC !== 16'h0040) begin bad++; $display("FAIL fetch_ignore_wait: got %h want 0040", nextPC); end
        imem_ready = 1'b1; #1;
        total++; if (nextPC !== 16'h0044) begin bad++; $display("FAIL fetch_ignore_ready: got %h want 0044", nextPC); end
        tick(); clear_redirect();
    endtask

    task automatic test_wrap();
        go_hold();
        instr_ready = 1'b1; jmp_valid = 1'b1; jmp_target = 16'hFFFC;
        tick(); clear_redirect();
        go_hold(); #1;
        total++; if (instr_pc !== 16'hFFFC) begin bad++; $display("FAIL wrap_instr_pc: got %h want FFFC", instr_pc); end
        instr_ready = 1'b1; #1;
        total++; if (nextPC !== 16'h0000) begin bad++; $display("FAIL wrap_nextpc: got %h want 0000", nextPC); end
        tick(); instr_ready = 1'b0; #1;
        total++; if (imem_addr !== 16'h0000) begin bad++; $display("FAIL wrap_fetch: got %h want 0000", imem_addr); end
    endtask

    task automatic test_reset_hold();
        go_hold(); pc = 16'h0ABC;
        reset = 1'b1; tick(); #1;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rsthold_valid: got %b want 0", instr_valid); end
        total++; if (nextPC !== 16'h0000 || imem_req !== 1'b0) begin bad++; $display("FAIL rsthold_quiet: got %h/%b want 0000/0", nextPC, imem_req); end
        reset = 1'b0; #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin bad++; $display("FAIL rsthold_refetch: got %b/%h want 1/0000", imem_req, imem_addr); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset       = ($urandom_range(0, 39) == 0);
            imem_ready  = 1'($urandom_range(0, 1));
            instr_ready = 1'($urandom_range(0, 1));
            br_taken    = 1'($urandom_range(0, 1));
            jmp_valid   = ($urandom_range(0, 3) == 0);
            br_offset   = 16'($urandom);
            jmp_target  = 16'($urandom);
            imem_rdata  = 16'($urandom);
            #1;
            total++; if (nextPC !== model_next()) begin bad++; $display("FAIL rnd_nextpc[%0d]: got %h want %h", i, nextPC, model_next()); end
            total++; if (imem_req !== (!reset && !m_hold)) begin bad++; $display("FAIL rnd_req[%0d]: got %b want %b", i, imem_req, (!reset && !m_hold)); end
            if (!reset && !m_hold) begin
                total++; if (imem_addr !== pc) begin bad++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, imem_addr, pc); end
            end
            total++; if (instr_valid !== m_hold) begin bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, instr_valid, m_hold); end
            total++; if (instr !== m_instr || instr_pc !== m_ipc) begin bad++; $display("FAIL rnd_instr[%0d]: got %h/%h want %h/%h", i, instr, instr_pc, m_instr, m_ipc); end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; pc = 16'h1234; imem_ready = 1'b0; imem_rdata = 16'h0000;
        instr_ready = 1'b0; br_taken = 1'b0; br_offset = 16'h0000; jmp_valid = 1'b0; jmp_target = 16'h0000;
        @(negedge clock);
        test_reset();
        test_sequential();
        test_mem_wait();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_reset_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
